pipeline_muldiv: RTL and testbench
==================================

// Module: pipeline_muldiv
// PURPOSE
//  Iterative multiply/divide sequencer for the pipeline EX stage; owns the HI/LO registers.
//  - Accepts mult/multu/div/divu from EX.
//  - Runs a 32-step shift-add or restoring-divide loop.
//  - Raises stall to hold IF/ID/EX while busy, or while mfhi/mflo/mthi/mtlo would see stale HI/LO.
// PARAMETERS
//  WIDTH   32  operand width; HI/LO width; iteration count
//  CNTW    6   step-counter width; must satisfy 2**CNTW > WIDTH
// PORTS
//  clk       in   1      clock, rising edge
//  reset     in   1      asynchronous, active-low; clears all state
//  start     in   1      EX holds a mul/div op; sampled only in IDLE
//  op        in   2      00 mult, 01 multu, 10 div, 11 divu
//  srca      in   WIDTH  rs value (multiplicand / dividend)
//  srcb      in   WIDTH  rt value (multiplier / divisor)
//  hilo_rd   in   1      EX holds mfhi/mflo
//  hi_we     in   1      mthi
//  lo_we     in   1      mtlo
//  wdata     in   WIDTH  mthi/mtlo data
//  flush     in   1      EX instruction squashed by branch/jump
//  stall     out  1      hold pipeline front end this cycle
//  busy      out  1      state != IDLE
//  done      out  1      one-cycle pulse, cycle after HI/LO update
//  hi        out  WIDTH  HI register
//  lo        out  WIDTH  LO register
// BEHAVIOUR
//  - Reset values: hi=0, lo=0, busy=0, done=0, stall=0; state=IDLE, cnt=0.
//  - States and transitions:
//    - IDLE -> CALC on start (not flush). Latch |srca|, |srcb|, result signs; cnt=0.
//    - CALC: one step per clock; cnt++. Leave to FIX when cnt==WIDTH-1.
//    - FIX: apply sign correction, write HI/LO, -> IDLE, done<=1.
//  - Latency: start sampled at edge N; HI/LO written at edge N+WIDTH+1 (33 for WIDTH=32);
//    busy is high for the WIDTH+1 cycles between those edges.
//  - stall = busy | (start & IDLE) | (busy & (hilo_rd|hi_we|lo_we)) combinational.
//    start is the issue cycle, so EX is held until done.
//  - Multiply: {hi,lo} = 2*WIDTH-bit product.
//    - Signed: operands magnitude-converted; product negated if signs differ.
//  - Divide: lo = quotient, hi = remainder.
//    - Signed: quotient negative if signs differ; remainder takes the dividend's sign.
//    - Divide by zero: lo=all-ones, hi=srca, full latency, no exception.
//    - Signed 0x80000000 / -1: lo=0x80000000, hi=0.
//  - mthi/mtlo: in IDLE, hi/lo written at the edge. Held off by stall while busy;
//    the pipeline reissues them.
//  - start while busy: ignored.
//  - flush: from any state, -> IDLE at the next edge; hi/lo unchanged, no done.
//    If flush and start in the same IDLE cycle, flush wins.
//  - Reset mid-operation: immediate return to the reset values; no partial HI/LO write.
// CONFIGURATION
//  - MULDIV_DIV_EN defined: div/divu behave as specified above.
//  - MULDIV_DIV_EN undefined: divide logic not built.
//    - op[1]=1 completes in 1 cycle: IDLE -> FIX -> IDLE, hi=lo=0, done pulses.
// STRUCTURE
//  - muldiv_defs.vh (shared header):
//    - op encodings MD_MULT/MD_MULTU/MD_DIV/MD_DIVU
//    - state codes S_IDLE/S_CALC/S_FIX
//  - Sub-module muldiv_step: combinational single iteration.
//    - Inputs: acc, operand, mode. Outputs: next acc/quotient bit.
//    - Instanced once; FSM, counter and HI/LO stay in pipeline_muldiv.
// TESTING
//  - multu 0xFFFFFFFF*0xFFFFFFFF -> hi=FFFFFFFE, lo=00000001 at edge N+33; done pulse 1 cycle;
//    stall high 34 cycles.
//  - mult -7*3 -> hi=FFFFFFFF, lo=FFFFFFEB.
//  - div -7/2 -> lo=FFFFFFFD, hi=FFFFFFFF.
//  - divu 100/0 -> lo=FFFFFFFF, hi=00000064.
//  - mfhi issued during busy -> stall held until done; the subsequent mfhi read returns the new hi.
//  - flush at cycle 10 of a mult, and reset at cycle 10 of another mult:
//    - flush -> busy drops next edge, hi/lo keep old values, no done.
//    - reset -> all outputs 0 immediately.
//  - Build without MULDIV_DIV_EN: divu 9/3 -> hi=lo=0, done one cycle after start.

Source files
------------

// File: rtl/pipeline_muldiv_pkg.sv
// rtl/pipeline_muldiv_pkg.sv - shared op encodings, state codes and defaults for pipeline_muldiv
package pipeline_muldiv_pkg;

  localparam int MD_WIDTH_DEFAULT = 32;
  localparam int MD_CNTW_DEFAULT  = 6;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } md_state_e;

endpackage

// File: rtl/pipeline_muldiv_step.sv
// rtl/pipeline_muldiv_step.sv - one combinational shift-add / restoring-divide iteration
//
// Ports:
//   acc      in   2*WIDTH  working register {upper, lower}
//   operand  in   WIDTH    multiplicand (mul) or divisor (div) magnitude
//   mode     in   1        0 = multiply step, 1 = divide step
//   acc_next out  2*WIDTH  register after this step; for divide the new
//                          quotient bit is acc_next[0]
// Configuration: MULDIV_DIV_EN builds the divide path; without it mode is ignored.
module pipeline_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               mode,
  output logic [2*WIDTH-1:0] acc_next
);

  // Multiply: upper half accumulates, whole register shifts right one bit;
  // the carry out of the add becomes the new top bit.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand & {WIDTH{acc[0]}}};

`ifdef MULDIV_DIV_EN
  // Divide: shift the next dividend bit into the partial remainder and try
  // a subtract. One extra guard bit keeps the sign test honest even when the
  // divisor is zero and the remainder fills all WIDTH bits.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  assign rem_sh = acc[2*WIDTH-1:WIDTH-1];
  assign diff   = {1'b0, rem_sh} - {2'b00, operand};

  always_comb begin
    acc_next = {mul_sum, acc[WIDTH-1:1]};
    if (mode) begin
      if (!diff[WIDTH+1]) begin
        acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign acc_next    = {mul_sum, acc[WIDTH-1:1]};
`endif

endmodule

// File: rtl/pipeline_muldiv.sv
// rtl/pipeline_muldiv.sv - iterative mult/div sequencer owning HI/LO for the EX stage
//
// Ports:
//   clk      in   1      rising-edge clock
//   reset    in   1      asynchronous active-low reset
//   start    in   1      EX holds mult/multu/div/divu (sampled in IDLE only)
//   op       in   2      00 mult, 01 multu, 10 div, 11 divu
//   srca     in   WIDTH  rs (multiplicand / dividend)
//   srcb     in   WIDTH  rt (multiplier / divisor)
//   hilo_rd  in   1      EX holds mfhi/mflo
//   hi_we    in   1      mthi
//   lo_we    in   1      mtlo
//   wdata    in   WIDTH  mthi/mtlo data
//   flush    in   1      EX instruction squashed
//   stall    out  1      hold IF/ID/EX
//   busy     out  1      sequencer not idle
//   done     out  1      one-cycle pulse after HI/LO update
//   hi, lo   out  WIDTH  HI/LO registers
// Configuration: MULDIV_DIV_EN builds div/divu; otherwise they finish in
// one cycle with hi=lo=0.
module pipeline_muldiv
  import pipeline_muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH_DEFAULT,
  parameter int CNTW  = MD_CNTW_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             hilo_rd,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e          state, state_d;
  md_op_e             op_e;
  logic [CNTW-1:0]    cnt;
  logic [2*WIDTH-1:0] acc, acc_next;
  logic [WIDTH-1:0]   opnd;
  logic               is_div, neg_res;
  logic               sgn, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_fix;
`ifdef MULDIV_DIV_EN
  logic               neg_rem, div_zero;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
`endif

  assign op_e  = md_op_e'(op);
  assign sgn   = (op_e == MD_MULT) || (op_e == MD_DIV);
  assign a_neg = sgn & srca[WIDTH-1];
  assign b_neg = sgn & srcb[WIDTH-1];
  assign a_mag = a_neg ? -srca : srca;
  assign b_mag = b_neg ? -srcb : srcb;

  assign busy  = (state != S_IDLE);
  assign stall = busy | (start & (state == S_IDLE)) | (busy & (hilo_rd | hi_we | lo_we));

  pipeline_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .operand  (opnd),
    .mode     (is_div),
    .acc_next (acc_next)
  );

  // Sign correction applied in FIX. Divide-by-zero forces an all-ones
  // quotient; the remainder then equals the dividend once its sign returns.
  assign prod_fix = neg_res ? -acc : acc;
`ifdef MULDIV_DIV_EN
  assign quo_fix  = div_zero ? {WIDTH{1'b1}} : (neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
  assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
`endif

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (start) begin
`ifdef MULDIV_DIV_EN
          state_d = S_CALC;
`else
          state_d = op[1] ? S_FIX : S_CALC;
`endif
        end
      end
      S_CALC:  if (cnt == CNTW'(WIDTH-1)) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
`endif
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      state <= state_d;
      done  <= 1'b0;
      // A squashed instruction leaves HI/LO and the datapath untouched.
      if (!flush) begin
        case (state)
          S_IDLE: begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
            if (start) begin
              is_div  <= (op_e == MD_DIV) || (op_e == MD_DIVU);
              neg_res <= a_neg ^ b_neg;
              cnt     <= '0;
`ifdef MULDIV_DIV_EN
              neg_rem  <= a_neg;
              div_zero <= (srcb == '0);
              if (op[1]) begin
                acc  <= {{WIDTH{1'b0}}, a_mag};
                opnd <= b_mag;
              end else begin
                acc  <= {{WIDTH{1'b0}}, b_mag};
                opnd <= a_mag;
              end
`else
              acc  <= {{WIDTH{1'b0}}, b_mag};
              opnd <= a_mag;
`endif
            end
          end
          S_CALC: begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
          end
          S_FIX: begin
`ifdef MULDIV_DIV_EN
            if (is_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              {hi, lo} <= prod_fix;
            end
`else
            if (is_div) begin
              hi <= '0;
              lo <= '0;
            end else begin
              {hi, lo} <= prod_fix;
            end
`endif
            done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipeline_muldiv.sv
// tb/tb_pipeline_muldiv.sv - self-checking bench for pipeline_muldiv
module tb_pipeline_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] srca = '0;
  logic [W-1:0] srcb = '0;
  logic         hilo_rd = 1'b0;
  logic         hi_we = 1'b0;
  logic         lo_we = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         flush = 1'b0;
  logic         stall, busy, done;
  logic [W-1:0] hi, lo;

  int nvec = 0;
  int nmis = 0;
  logic [2*W-1:0] exp_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t tbl[10];

  pipeline_muldiv #(.WIDTH(W), .CNTW(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .hilo_rd(hilo_rd), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .flush(flush),
    .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: native 64-bit arithmetic, divide cases per the HI/LO rules.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int     sa, sb;
    logic [63:0] r;
    sa = a;
    sb = b;
    case (o)
      2'b00: begin p = longint'(sa) * longint'(sb); r = p; end
      2'b01: r = {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
        else r = {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
    endcase
`ifndef MULDIV_DIV_EN
    if (o[1]) r = '0;
`endif
    return r;
  endfunction

  // Scoreboard: every done pulse consumes the oldest expected {hi,lo}.
  always @(negedge clk) begin
    if (reset && done) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nmis++;
        $display("FAIL unexpected_done: got hi=%h lo=%h expected no done", hi, lo);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("done_result", {hi, lo}, e);
      end
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [63:0] e);
    int k;
    exp_q.push_back(e);
    op = o; srca = a; srcb = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      nvec++;
      nmis++;
      $display("FAIL op_timeout: got no done expected done within 60 cycles (op=%0d)", o);
      exp_q.delete();
    end
  endtask

  task automatic timed_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] e, input int lat);
    int sc, bc, dc, first_done;
    exp_q.push_back(e);
    op = o; srca = a; srcb = b; start = 1'b1;
    #1;
    sc = stall ? 1 : 0;
    bc = 0; dc = 0; first_done = -1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < lat + 6; k++) begin
      if (stall) sc++;
      if (busy) bc++;
      if (done) begin
        dc++;
        if (first_done < 0) first_done = k;
      end
      @(negedge clk);
    end
    if (dc == 0) exp_q.delete();
    check({name, "_latency"}, 64'(first_done), 64'(lat));
    check({name, "_done_width"}, 64'(dc), 64'd1);
    check({name, "_busy_cycles"}, 64'(bc), 64'(lat));
    check({name, "_stall_cycles"}, 64'(sc), 64'(lat + 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] e;
    int lapses, dc;
    logic [1:0] ro;
    logic [31:0] ra, rb;

    tbl[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    tbl[1] = '{2'b00, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    tbl[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3] = '{2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
    tbl[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    tbl[5] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    tbl[6] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    tbl[7] = '{2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
    tbl[8] = '{2'b11, 32'h0000_0009, 32'h0000_0003, 32'h0000_0000, 32'h0000_0003};
    tbl[9] = '{2'b00, 32'h1234_5678, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hEDCB_A988};

    #1;
    check("reset_outputs", {28'd0, stall, busy, done, 1'b0, hi, lo}, 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Worst-case multu with full timing
    timed_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33);

    for (int i = 0; i < 10; i++) begin
      e = {tbl[i].exp_hi, tbl[i].exp_lo};
`ifndef MULDIV_DIV_EN
      if (tbl[i].op[1]) e = '0;
`endif
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, e);
    end

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      run_op(ro, ra, rb, model(ro, ra, rb));
    end

    // divu 9/3 timing: full loop with divide built, one cycle without
`ifdef MULDIV_DIV_EN
    timed_op("divu_9_3", 2'b11, 32'd9, 32'd3, {32'd0, 32'd3}, 33);
`else
    timed_op("divu_9_3", 2'b11, 32'd9, 32'd3, 64'd0, 1);
`endif

    // mthi / mtlo in IDLE
    hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h0BAD_F00D;
    @(negedge clk);
    lo_we = 1'b0;
    check("mthi_mtlo", {hi, lo}, 64'hDEAD_BEEF_0BAD_F00D);

    // mfhi arriving mid-operation stays stalled until the new HI lands
    exp_q.push_back(64'h0000_0003_0000_0000);
    op = 2'b01; srca = 32'h0001_0000; srcb = 32'h0003_0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    hilo_rd = 1'b1;
    lapses = 0;
    dc = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (!stall) lapses++;
      @(negedge clk);
    end
    check("mfhi_stall_held", 64'(lapses), 64'd0);
    check("mfhi_new_hi", {32'd0, hi}, 64'h0000_0003);
    hilo_rd = 1'b0;
    @(negedge clk);

    // flush at cycle 10
    hi_we = 1'b1; wdata = 32'h1111_1111;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h2222_2222;
    @(negedge clk);
    lo_we = 1'b0;
    op = 2'b01; srca = 32'd5; srcb = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    dc = 0;
    repeat (40) begin
      if (done) dc++;
      @(negedge clk);
    end
    check("flush_no_done", 64'(dc), 64'd0);
    check("flush_hilo_kept", {hi, lo}, 64'h1111_1111_2222_2222);

    // reset at cycle 10
    op = 2'b00; srca = 32'd123; srcb = 32'd456; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midop_reset", {29'd0, stall, busy, done, hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("post_reset_hilo", {hi, lo}, 64'd0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
